branch_redirect_ctrl: RTL

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: turns branch-unit redirect and halt requests
// into fetch select/flush/hold controls. A redirect that arrives while the
// pipeline is stalled is parked in a pending register until the stall
// clears. Also keeps saturating branch and taken-redirect counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch; redirects issue immediately when not stalled
// HOLD  | redirect parked in pend_target, waiting for stall to drop
// HALT  | core halted; fetch PC frozen until reset
module branch_redirect_ctrl #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             halt_com,
    input  logic             stall,
    output logic             pc_sel,
    output logic [PC_W-1:0]  pc_target,
    output logic             pc_hold,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pend_target;
    logic [PC_W-1:0] new_target;
    logic            pend_load;
    logic            misalign_set;
    logic            sel_raw, flush_raw, hold_raw, halted_raw;
    logic            br_inc;

    // Upper target bits beyond the instruction-memory width are dropped on purpose.
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^BrPC[31:PC_W];

    assign new_target = {BrPC[PC_W-1:2], 2'b00};

    // Next-state and raw control decode; halt wins over a simultaneous redirect.
    always_comb begin
        state_nxt    = state;
        sel_raw      = 1'b0;
        flush_raw    = 1'b0;
        hold_raw     = 1'b0;
        halted_raw   = 1'b0;
        pend_load    = 1'b0;
        misalign_set = 1'b0;
        pc_target    = pend_target;
        case (state)
            RUN: begin
                if (ex_valid && halt_com) begin
                    flush_raw = 1'b1;
                    state_nxt = HALT;
                end else if (ex_valid && PcSel) begin
                    misalign_set = |BrPC[1:0];
                    if (stall) begin
                        pend_load = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        sel_raw   = 1'b1;
                        flush_raw = 1'b1;
                        pc_target = new_target;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    sel_raw   = 1'b1;
                    flush_raw = 1'b1;
                    state_nxt = RUN;
                end
            end
            HALT: begin
                hold_raw   = 1'b1;
                halted_raw = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Controls are forced low while reset is asserted, even with a request present.
    always_comb begin
        pc_sel     = sel_raw    & ~reset;
        flush_ifid = flush_raw  & ~reset;
        flush_idex = flush_raw  & ~reset;
        pc_hold    = hold_raw   & ~reset;
        halted     = halted_raw & ~reset;
    end

    assign br_inc = (state == RUN) && ex_valid && ex_branch && !stall;

    // State, pending target, sticky misalignment flag and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            pend_target  <= '0;
            misalign_err <= 1'b0;
            br_cnt       <= '0;
            taken_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (pend_load)
                pend_target <= new_target;
            if (misalign_set)
                misalign_err <= 1'b1;
            if (br_inc && (br_cnt != '1))
                br_cnt <= br_cnt + CNT_W'(1);
            if (pc_sel && (taken_cnt != '1))
                taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

endmodule
